// File: rtl/ili_pkg.sv
// Shared types and constants for the ILI9341 command sequencer and its init ROM.
package ili_pkg;

   typedef enum logic [1:0] {
      CMD   = 2'd0,
      DATA  = 2'd1,
      DELAY = 2'd2,
      END   = 2'd3
   } ili_kind_e;

   typedef enum logic [3:0] {
      ST_HW_RST,
      ST_POST_RST,
      ST_FETCH,
      ST_DECODE,
      ST_DELAY,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_READY
   } seq_state_e;

   typedef struct packed {
      ili_kind_e  kind;
      logic [7:0] payload;
   } ili_rom_entry_t;

   localparam logic [7:0] SWRESET = 8'h01;
   localparam logic [7:0] SLPOUT  = 8'h11;
   localparam logic [7:0] DISPON  = 8'h29;
   localparam logic [7:0] PIXFMT  = 8'h3A;
   localparam logic [7:0] MADCTL  = 8'h36;

   function automatic ili_rom_entry_t mkEntry(input ili_kind_e k, input logic [7:0] p);
      ili_rom_entry_t e;
      e.kind    = k;
      e.payload = p;
      return e;
   endfunction

endpackage

// File: rtl/ili_init_rom.sv
// Synchronous case-ROM of init entries; unlisted addresses read as END.
// ROM_SEL picks the table: 0 = panel bring-up, 1 = short test sequence, 2 = CMD-only table without END.
module ili_init_rom
   import ili_pkg::*;
#(
   parameter int ROM_DEPTH = 64,
   parameter int ROM_SEL   = 0
) (
   input  logic                         i_clk,
   input  logic [$clog2(ROM_DEPTH)-1:0] i_addr,
   output ili_rom_entry_t               o_entry
);

   ili_rom_entry_t w_entry;

   always_comb begin
      w_entry = mkEntry(END, 8'h00);
      if (ROM_SEL == 2) begin
         w_entry = mkEntry(CMD, 8'(i_addr));
      end else if (ROM_SEL == 1) begin
         case (int'(i_addr))
            0:       w_entry = mkEntry(CMD,   SWRESET);
            1:       w_entry = mkEntry(DELAY, 8'd1);
            2:       w_entry = mkEntry(CMD,   SLPOUT);
            3:       w_entry = mkEntry(DATA,  8'h55);
            default: w_entry = mkEntry(END,   8'h00);
         endcase
      end else begin
         case (int'(i_addr))
            0:       w_entry = mkEntry(CMD,   SWRESET);
            1:       w_entry = mkEntry(DELAY, 8'd5);
            2:       w_entry = mkEntry(CMD,   SLPOUT);
            3:       w_entry = mkEntry(DELAY, 8'd120);
            4:       w_entry = mkEntry(CMD,   PIXFMT);
            5:       w_entry = mkEntry(DATA,  8'h55);
            6:       w_entry = mkEntry(CMD,   MADCTL);
            7:       w_entry = mkEntry(DATA,  8'h48);
            8:       w_entry = mkEntry(CMD,   DISPON);
            default: w_entry = mkEntry(END,   8'h00);
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      o_entry <= w_entry;
   end

endmodule

// File: rtl/ili_cmd_sequencer.sv
// ILI9341 command sequencer: pulses the panel reset, walks the init ROM, then
// serialises user byte writes, so the SPI byte master has a single owner.
module ili_cmd_sequencer
   import ili_pkg::*;
#(
   parameter int DELAY_UNIT     = 100000,
   parameter int HW_RST_UNITS   = 10,
   parameter int POST_RST_UNITS = 120,
   parameter int ROM_DEPTH      = 64,
   parameter int ROM_SEL        = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_spi_idle,
   output logic       o_spi_send,
   output logic [7:0] o_spi_byte,
   output logic       o_dc,
   output logic       o_rst_ili,
   input  logic       i_wr_req,
   input  logic       i_wr_dc,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_ack,
   output logic       o_init_done
);

   localparam int AW           = $clog2(ROM_DEPTH);
   localparam int CNT_W        = $clog2(255 * DELAY_UNIT + 1);
   localparam int HW_RST_CYC   = HW_RST_UNITS * DELAY_UNIT;
   localparam int POST_RST_CYC = POST_RST_UNITS * DELAY_UNIT;
   localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

   seq_state_e     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [AW-1:0]  r_addr;
   logic           r_romLast;
   logic           r_spiSend;
   logic           r_wrAck;
   logic [7:0]     r_spiByte;
   logic           r_dc;
   logic           r_rstIli;
   logic           r_initDone;

   ili_rom_entry_t   w_entry;
   seq_state_e       w_nextState;
   logic [CNT_W-1:0] w_cntNext;
   logic             w_send;
   logic             w_ack;
   logic             w_latchRom;
   logic             w_latchUser;
   logic             w_advance;
   logic             w_setDone;
   logic             w_releaseRst;

   ili_init_rom #(
      .ROM_DEPTH (ROM_DEPTH),
      .ROM_SEL   (ROM_SEL)
   ) u_rom (
      .i_clk   (i_clk),
      .i_addr  (r_addr),
      .o_entry (w_entry)
   );

   // Once the last ROM slot has been consumed, the next decode acts as END so the address never wraps.
   always_comb begin
      w_nextState  = r_state;
      w_cntNext    = r_cnt;
      w_send       = 1'b0;
      w_ack        = 1'b0;
      w_latchRom   = 1'b0;
      w_latchUser  = 1'b0;
      w_advance    = 1'b0;
      w_setDone    = 1'b0;
      w_releaseRst = 1'b0;
      case (r_state)
         ST_HW_RST: begin
            if (r_cnt == CNT_W'(HW_RST_CYC - 1)) begin
               w_cntNext    = '0;
               w_releaseRst = 1'b1;
               w_nextState  = ST_POST_RST;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         ST_POST_RST: begin
            if (r_cnt == CNT_W'(POST_RST_CYC - 1)) begin
               w_cntNext   = '0;
               w_nextState = ST_FETCH;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         ST_FETCH: w_nextState = ST_DECODE;
         ST_DECODE: begin
            if (r_romLast || (w_entry.kind == END)) begin
               w_setDone   = 1'b1;
               w_nextState = ST_READY;
            end else begin
               w_advance = 1'b1;
               if (w_entry.kind == DELAY) begin
                  w_cntNext   = CNT_W'(w_entry.payload) * CNT_W'(DELAY_UNIT);
                  w_nextState = ST_DELAY;
               end else begin
                  w_latchRom  = 1'b1;
                  w_nextState = ST_ISSUE;
               end
            end
         end
         ST_DELAY: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_cntNext   = '0;
               w_nextState = ST_FETCH;
            end else begin
               w_cntNext = r_cnt - CNT_W'(1);
            end
         end
         ST_ISSUE: begin
            if (i_spi_idle) begin
               w_send      = 1'b1;
               w_nextState = ST_WAIT_START;
            end
         end
         ST_WAIT_START: if (!i_spi_idle) w_nextState = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (i_spi_idle) w_nextState = r_initDone ? ST_READY : ST_FETCH;
         end
         ST_READY: begin
            if (i_wr_req && i_spi_idle) begin
               w_send      = 1'b1;
               w_ack       = 1'b1;
               w_latchUser = 1'b1;
               w_nextState = ST_WAIT_START;
            end
         end
         default: w_nextState = ST_HW_RST;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_HW_RST;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_romLast  <= 1'b0;
         r_spiSend  <= 1'b0;
         r_wrAck    <= 1'b0;
         r_spiByte  <= 8'h00;
         r_dc       <= 1'b0;
         r_rstIli   <= 1'b0;
         r_initDone <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_cntNext;
         r_spiSend <= w_send;
         r_wrAck   <= w_ack;
         if (w_releaseRst) r_rstIli <= 1'b1;
         if (w_setDone) r_initDone <= 1'b1;
         if (w_latchRom) begin
            r_spiByte <= w_entry.payload;
            r_dc      <= (w_entry.kind == DATA);
         end
         if (w_latchUser) begin
            r_spiByte <= i_wr_data;
            r_dc      <= i_wr_dc;
         end
         if (w_advance) begin
            if (r_addr == LAST_ADDR) r_romLast <= 1'b1;
            else r_addr <= r_addr + AW'(1);
         end
      end
   end

   assign o_spi_send  = r_spiSend;
   assign o_wr_ack    = r_wrAck;
   assign o_spi_byte  = r_spiByte;
   assign o_dc        = r_dc;
   assign o_rst_ili   = r_rstIli;
   assign o_init_done = r_initDone;

endmodule

// File: tb/tb_ili_cmd_sequencer.sv
// Directed bench: instance A runs the short test ROM, instance B a ROM without END;
// each talks to a behavioural SPI master that stays busy 8 cycles per byte.
`timescale 1ns/1ps
module tb_ili_cmd_sequencer;

   localparam int DU       = 4;
   localparam int SPI_BUSY = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rstA_n = 1'b0, rstB_n = 1'b0;
   logic       spiIdleA, spiIdleB, holdA = 1'b0;
   wire        idleA = spiIdleA & ~holdA;
   wire        idleB = spiIdleB;
   logic       sendA, sendB, dcA, dcB, rstIliA, rstIliB, ackA, ackB, doneA, doneB;
   logic [7:0] byteA, byteB;
   logic       wrReqA = 1'b0, wrDcA = 1'b0, wrReqB = 1'b0;
   logic [7:0] wrDataA = 8'h00;
   int         busyA = 0, busyB = 0, compA = 0;

   ili_cmd_sequencer #(.DELAY_UNIT(DU), .HW_RST_UNITS(10), .POST_RST_UNITS(120), .ROM_DEPTH(64), .ROM_SEL(1)) dutA (
      .i_clk(clk), .i_rst_n(rstA_n), .i_spi_idle(idleA), .o_spi_send(sendA), .o_spi_byte(byteA),
      .o_dc(dcA), .o_rst_ili(rstIliA), .i_wr_req(wrReqA), .i_wr_dc(wrDcA), .i_wr_data(wrDataA),
      .o_wr_ack(ackA), .o_init_done(doneA));

   ili_cmd_sequencer #(.DELAY_UNIT(DU), .HW_RST_UNITS(10), .POST_RST_UNITS(120), .ROM_DEPTH(64), .ROM_SEL(2)) dutB (
      .i_clk(clk), .i_rst_n(rstB_n), .i_spi_idle(idleB), .o_spi_send(sendB), .o_spi_byte(byteB),
      .o_dc(dcB), .o_rst_ili(rstIliB), .i_wr_req(wrReqB), .i_wr_dc(1'b0), .i_wr_data(8'h00),
      .o_wr_ack(ackB), .o_init_done(doneB));

   always @(posedge clk or negedge rstA_n) begin
      if (!rstA_n) begin
         spiIdleA <= 1'b1;
         busyA    <= 0;
      end else if (busyA != 0) begin
         busyA <= busyA - 1;
         if (busyA == 1) begin
            spiIdleA <= 1'b1;
            compA    <= compA + 1;
         end
      end else if (sendA) begin
         spiIdleA <= 1'b0;
         busyA    <= SPI_BUSY;
      end
   end

   always @(posedge clk or negedge rstB_n) begin
      if (!rstB_n) begin
         spiIdleB <= 1'b1;
         busyB    <= 0;
      end else if (busyB != 0) begin
         busyB <= busyB - 1;
         if (busyB == 1) spiIdleB <= 1'b1;
      end else if (sendB) begin
         spiIdleB <= 1'b0;
         busyB    <= SPI_BUSY;
      end
   end

   logic [7:0] logByteA [0:255];
   logic       logDcA   [0:255];
   logic       logDoneA [0:255];
   int         logCycA  [0:255];
   int nA = 0, nAckA = 0, ackEarlyA = 0, ackNoSendA = 0, ackBadA = 0, sendBusyA = 0;
   int nB = 0, orderErrB = 0, sendBusyB = 0;
   logic [7:0] expUserByte = 8'hA5, lastByteB = 8'h00;
   logic       expUserDc = 1'b1, doneAtLastB = 1'b0;

   always @(posedge clk) begin
      if (sendA) begin
         if (nA < 256) begin
            logByteA[nA] = byteA;
            logDcA[nA]   = dcA;
            logDoneA[nA] = doneA;
            logCycA[nA]  = cyc;
         end
         nA = nA + 1;
         if (!idleA) sendBusyA = sendBusyA + 1;
      end
      if (ackA) begin
         nAckA = nAckA + 1;
         if (!doneA) ackEarlyA = ackEarlyA + 1;
         if (!sendA) ackNoSendA = ackNoSendA + 1;
         if (byteA !== expUserByte || dcA !== expUserDc) ackBadA = ackBadA + 1;
      end
      if (sendB) begin
         if (byteB !== 8'(nB) || dcB !== 1'b0) orderErrB = orderErrB + 1;
         if (!idleB) sendBusyB = sendBusyB + 1;
         lastByteB   = byteB;
         doneAtLastB = doneB;
         nB = nB + 1;
      end
   end

   task automatic test_reset();
      wrReqA = 1'b1; wrDataA = 8'hA5; wrDcA = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rstIliA !== 1'b0) begin errors++; $display("[TB] FAIL reset_rst_ili: got %b want 0", rstIliA); end
      checks++; if (sendA !== 1'b0) begin errors++; $display("[TB] FAIL reset_spi_send: got %b want 0", sendA); end
      checks++; if (ackA !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ack: got %b want 0", ackA); end
      checks++; if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b want 0", doneA); end
      checks++; if (byteA !== 8'h00) begin errors++; $display("[TB] FAIL reset_spi_byte: got %h want 00", byteA); end
      checks++; if (dcA !== 1'b0) begin errors++; $display("[TB] FAIL reset_dc: got %b want 0", dcA); end
      checks++; if (rstIliB !== 1'b0 || doneB !== 1'b0) begin errors++; $display("[TB] FAIL reset_b: got rst_ili=%b done=%b want 0/0", rstIliB, doneB); end
   endtask

   // rst_ili low for 10*DU cycles; then 120*DU post-reset cycles plus FETCH/DECODE/ISSUE before spi_send.
   task automatic test_reset_release();
      int n, m;
      @(negedge clk); rstA_n = 1'b1;
      n = 0;
      while (rstIliA !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++; if (n != 10 * DU) begin errors++; $display("[TB] FAIL hw_rst_len: got %0d cycles want %0d", n, 10 * DU); end
      m = 0;
      while (sendA !== 1'b1 && m < 1000) begin @(negedge clk); m++; end
      checks++; if (m < 120 * DU || m > 120 * DU + 4) begin errors++; $display("[TB] FAIL post_rst_len: got %0d cycles want %0d..%0d", m, 120 * DU, 120 * DU + 4); end
   endtask

   task automatic test_init_sequence();
      int n, gap01, gap12;
      n = 0;
      while (doneA !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      checks++; if (doneA !== 1'b1) begin errors++; $display("[TB] FAIL init_done_timeout: got %b want 1", doneA); end
      checks++; if (nA != 3) begin errors++; $display("[TB] FAIL init_byte_count: got %0d want 3", nA); end
      checks++; if (logByteA[0] !== 8'h01 || logDcA[0] !== 1'b0) begin errors++; $display("[TB] FAIL init_byte0: got %h/%b want 01/0", logByteA[0], logDcA[0]); end
      checks++; if (logByteA[1] !== 8'h11 || logDcA[1] !== 1'b0) begin errors++; $display("[TB] FAIL init_byte1: got %h/%b want 11/0", logByteA[1], logDcA[1]); end
      checks++; if (logByteA[2] !== 8'h55 || logDcA[2] !== 1'b1) begin errors++; $display("[TB] FAIL init_byte2: got %h/%b want 55/1", logByteA[2], logDcA[2]); end
      checks++; if (logDoneA[2] !== 1'b0 || spiIdleA !== 1'b1) begin errors++; $display("[TB] FAIL init_done_early: got done_at_55=%b idle=%b want 0/1", logDoneA[2], spiIdleA); end
      gap01 = logCycA[1] - logCycA[0];
      gap12 = logCycA[2] - logCycA[1];
      checks++; if (gap01 < DU + SPI_BUSY) begin errors++; $display("[TB] FAIL delay_gap_min: got %0d want >= %0d", gap01, DU + SPI_BUSY); end
      // The DELAY entry adds its own FETCH and DECODE plus DU counted cycles over a plain byte gap.
      checks++; if (gap01 - gap12 != DU + 2) begin errors++; $display("[TB] FAIL delay_gap_extra: got %0d want %0d", gap01 - gap12, DU + 2); end
      checks++; if (gap12 < SPI_BUSY + 3 || gap12 > SPI_BUSY + 5) begin errors++; $display("[TB] FAIL byte_gap: got %0d want %0d..%0d", gap12, SPI_BUSY + 3, SPI_BUSY + 5); end
   endtask

   task automatic test_user_writes();
      int ackBase, sendBase, compBase, acks, sends, comps, n;
      checks++; if (ackEarlyA != 0) begin errors++; $display("[TB] FAIL ack_before_done: got %0d want 0", ackEarlyA); end
      ackBase = nAckA; sendBase = nA; compBase = compA;
      repeat (60) @(negedge clk);
      acks = nAckA - ackBase; sends = nA - sendBase; comps = compA - compBase;
      checks++; if (acks < 4 || acks != sends) begin errors++; $display("[TB] FAIL user_ack_count: got acks=%0d sends=%0d want acks>=4 and equal", acks, sends); end
      checks++; if (acks - comps < 0 || acks - comps > 1) begin errors++; $display("[TB] FAIL ack_per_byte: got acks=%0d done=%0d want diff 0..1", acks, comps); end
      wrReqA = 1'b0;
      repeat (15) @(negedge clk);
      expUserByte = 8'h3C; expUserDc = 1'b0;
      wrDataA = 8'h3C; wrDcA = 1'b0; wrReqA = 1'b1;
      n = 0;
      while (ackA !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (ackA !== 1'b1 || sendA !== 1'b1) begin errors++; $display("[TB] FAIL user_ack_pulse: got ack=%b send=%b want 1/1", ackA, sendA); end
      checks++; if (byteA !== 8'h3C || dcA !== 1'b0) begin errors++; $display("[TB] FAIL user_byte2: got %h/%b want 3C/0", byteA, dcA); end
      wrReqA = 1'b0;
      repeat (12) @(negedge clk);
      ackBase = nAckA;
      repeat (30) @(negedge clk);
      checks++; if (nAckA != ackBase) begin errors++; $display("[TB] FAIL ack_without_req: got %0d want 0", nAckA - ackBase); end
      checks++; if (ackBadA != 0 || ackNoSendA != 0) begin errors++; $display("[TB] FAIL ack_payload: got bad=%0d nosend=%0d want 0/0", ackBadA, ackNoSendA); end
   endtask

   task automatic test_reset_mid_op();
      int n, sendBase;
      @(negedge clk); #2 rstA_n = 1'b0; #1;
      checks++; if (doneA !== 1'b0 || byteA !== 8'h00 || rstIliA !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ready: got done=%b byte=%h rst_ili=%b want 0/00/0", doneA, byteA, rstIliA); end
      @(negedge clk); rstA_n = 1'b1;
      sendBase = nA; n = 0;
      while (nA - sendBase < 2 && n < 2000) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      checks++; if (byteA !== 8'h11 || spiIdleA !== 1'b0) begin errors++; $display("[TB] FAIL byte2_in_flight: got byte=%h idle=%b want 11/0", byteA, spiIdleA); end
      #2 rstA_n = 1'b0; #1;
      checks++; if (byteA !== 8'h00 || dcA !== 1'b0 || rstIliA !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_byte: got byte=%h dc=%b rst_ili=%b want 00/0/0", byteA, dcA, rstIliA); end
      checks++; if (sendA !== 1'b0 || ackA !== 1'b0 || doneA !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ctl: got send=%b ack=%b done=%b want 0/0/0", sendA, ackA, doneA); end
   endtask

   task automatic test_idle_stall();
      int n, stallSends, sendBase;
      @(negedge clk); rstA_n = 1'b1;
      n = 0;
      while (rstIliA !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++; if (n != 10 * DU) begin errors++; $display("[TB] FAIL restart_hw_rst: got %0d want %0d", n, 10 * DU); end
      repeat (120 * DU + 1) @(negedge clk);
      holdA = 1'b1; stallSends = 0;
      repeat (20) begin @(negedge clk); if (sendA) stallSends++; end
      checks++; if (stallSends != 0) begin errors++; $display("[TB] FAIL send_while_busy: got %0d pulses want 0", stallSends); end
      sendBase = nA; holdA = 1'b0;
      repeat (14) @(negedge clk);
      checks++; if (nA - sendBase != 1) begin errors++; $display("[TB] FAIL stall_release_pulses: got %0d want 1", nA - sendBase); end
      checks++; if (logByteA[sendBase] !== 8'h01 || logDcA[sendBase] !== 1'b0) begin errors++; $display("[TB] FAIL restart_first_byte: got %h/%b want 01/0", logByteA[sendBase], logDcA[sendBase]); end
   endtask

   task automatic test_no_end();
      int n, nAfter;
      @(negedge clk); rstB_n = 1'b1;
      n = 0;
      while (doneB !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      checks++; if (doneB !== 1'b1) begin errors++; $display("[TB] FAIL noend_done_timeout: got %b want 1", doneB); end
      checks++; if (nB != 64 || lastByteB !== 8'h3F) begin errors++; $display("[TB] FAIL noend_count: got %0d last=%h want 64/3F", nB, lastByteB); end
      checks++; if (orderErrB != 0 || doneAtLastB !== 1'b0) begin errors++; $display("[TB] FAIL noend_order: got errs=%0d done_at_63=%b want 0/0", orderErrB, doneAtLastB); end
      nAfter = nB;
      repeat (100) @(negedge clk);
      checks++; if (nB != nAfter) begin errors++; $display("[TB] FAIL noend_wrap: got %0d extra sends want 0", nB - nAfter); end
      checks++; if (sendBusyA != 0 || sendBusyB != 0) begin errors++; $display("[TB] FAIL send_vs_idle: got A=%0d B=%0d want 0/0", sendBusyA, sendBusyB); end
   endtask

   initial begin
      test_reset();
      test_reset_release();
      test_init_sequence();
      test_user_writes();
      test_reset_mid_op();
      test_idle_stall();
      test_no_end();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ili_cmd_sequencer.md
# ili_cmd_sequencer

Command sequencer in front of the SPI byte master for the ILI9341 panel. After reset it pulses the panel hardware reset, then walks an init ROM of command, data and delay entries. Each byte is issued to the SPI master with the correct D/C level. Afterwards it serialises user byte-write requests onto the same SPI master, so the datapath has a single owner.

## Interface
- `DELAY_UNIT`, 100000: clk cycles per delay unit (1 ms at 100 MHz).
- `HW_RST_UNITS`, 10: delay units `rst_ili` is held low.
- `POST_RST_UNITS`, 120: delay units after `rst_ili` release before the first ROM fetch.
- `ROM_DEPTH`, 64: init ROM entries; address width is `$clog2(ROM_DEPTH)`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is asynchronous and active-low.
- `spi_idle` in 1: SPI master idle/done level, high when the master is free.
- `spi_send` out 1: one-cycle start pulse to the SPI master.
- `spi_byte` out 8: byte to shift out, held stable from `spi_send` until `spi_idle` returns high.
- `dc` out 1: panel D/C, 0 = command, 1 = data; held with `spi_byte`.
- `rst_ili` out 1: panel hardware reset, active-low.
- `wr_req` in 1: user write request (level).
- `wr_dc` in 1: D/C for the user byte.
- `wr_data` in 8: user byte.
- `wr_ack` out 1: one-cycle pulse when the user byte is accepted (same cycle as its `spi_send`).
- `init_done` out 1: high once the ROM END entry is reached; sticky until reset.

## Operation
- ROM entry is 10 bits, `{kind[1:0], payload[7:0]}`.
  - CMD=0: send payload with dc=0.
  - DATA=1: send payload with dc=1.
  - DELAY=2: wait payload×`DELAY_UNIT` cycles; payload 0 means no wait.
  - END=3: initialisation complete.
- FSM states: HW_RST, POST_RST, FETCH, DECODE, DELAY, ISSUE, WAIT_START, WAIT_DONE, READY.
- HW_RST: `rst_ili`=0; count `HW_RST_UNITS`×`DELAY_UNIT` cycles, then `rst_ili`=1 and go to POST_RST.
- POST_RST: count `POST_RST_UNITS`×`DELAY_UNIT` cycles, then go to FETCH with address 0.
- FETCH: present the address to the ROM. The ROM is synchronous, so the entry is valid in DECODE.
- DECODE:
  - CMD/DATA latch `spi_byte`/`dc` and go to ISSUE.
  - DELAY loads the counter and goes to DELAY.
  - END sets `init_done` and goes to READY.
  - Address increments on every non-END decode.
  - If address reaches `ROM_DEPTH`-1 without END, the next decode is treated as END; no wrap-around.
- DELAY: count down, then go to FETCH.
- ISSUE: wait for `spi_idle`=1, then pulse `spi_send` and go to WAIT_START.
- WAIT_START: wait for `spi_idle`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `spi_idle`=1, then return to FETCH (init phase) or READY (user phase).
- READY: if `wr_req`=1 and `spi_idle`=1:
  - latch `wr_data`/`wr_dc`;
  - pulse `spi_send` and `wr_ack` in the same cycle;
  - go to WAIT_START.
- Arbitration: user requests are ignored (no `wr_ack`) until `init_done`. The ROM always has priority.
- `wr_req` held high across a completed byte yields a new acceptance only after WAIT_DONE.
- Delay counter width is `$clog2(255×DELAY_UNIT+1)`; products are computed at elaboration or via the unit-counter/units-counter pair.

## Timing
- Reset values:
  - `rst_ili`=0, `spi_send`=0, `wr_ack`=0, `init_done`=0, `spi_byte`=8'h00, `dc`=0.
  - State HW_RST, all counters 0.
- Reset mid-operation: immediate return to HW_RST. A byte in flight in the SPI master is abandoned; the SPI master is reset by the same `rst`.
- CMD/DATA entry: FETCH→DECODE→ISSUE gives `spi_send` 2 cycles after entering FETCH when `spi_idle`=1.
- Byte to byte: WAIT_DONE exit → FETCH → DECODE → ISSUE gives 3 cycles of gap after `spi_idle` rises.
- User path: `wr_ack`/`spi_send` occur in the first READY cycle with `wr_req`=`spi_idle`=1.
- `spi_send` is never asserted while `spi_idle`=0.
- `spi_send` and `wr_ack` are registered outputs.
- DELAY entry with payload N holds for exactly N×`DELAY_UNIT` cycles (±1) before the next FETCH.

## Structure
- Package `ili_pkg` holds:
  - kind enum `ili_kind_e` (CMD, DATA, DELAY, END);
  - state enum `seq_state_e`;
  - typedef `ili_rom_entry_t` (packed struct kind/payload);
  - ILI9341 opcode constants (SWRESET 8'h01, SLPOUT 8'h11, DISPON 8'h29, PIXFMT 8'h3A, MADCTL 8'h36).
- Sub-module `ili_init_rom`: synchronous case-ROM indexed by address, returning `ili_rom_entry_t`; the default entry is END.

## Test plan
- Reset release with `DELAY_UNIT`=4 → `rst_ili` low exactly 40 cycles, then 480 cycles until the first `spi_send`.
- ROM {CMD 8'h01, DELAY 1, CMD 8'h11, DATA 8'h55, END} with an SPI model (idle low 8 cycles per byte):
  - bytes 01/dc0, 11/dc0, 55/dc1 in order;
  - ≥`DELAY_UNIT` cycles between the first two bytes;
  - `init_done` rises after 55 completes.
- `wr_req`=1, `wr_data`=8'hA5, `wr_dc`=1 held during init → no `wr_ack` before `init_done`; afterwards exactly one `wr_ack` per completed byte, with `spi_byte`=A5 and `dc`=1.
- `spi_idle` forced low in ISSUE for 20 cycles → `spi_send` stays 0 until idle returns, then a single pulse.
- `rst` asserted during WAIT_DONE of byte 2 → all outputs at reset values asynchronously; the sequence restarts from HW_RST and reissues 8'h01 first.
- ROM with no END in 64 entries → `init_done` rises after entry 63 and the address never wraps to 0.
